// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Operands are registered on accept, the ALU result is captured in EXEC and returned in RESP.
module alu_share_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [1:0]        op_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              grant;
    logic              accept;
    logic              rsp_fire;

    // Ready is held low during reset even though the state already reads as idle.
    always_comb begin
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        if ((state_q == StIdle) && rst_n) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
        end
    end

    assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_fire = (state_q == StResp) && (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'b00;
            owner_q      <= 1'b0;
            result_q     <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= grant ? req1_a  : req0_a;
                b_q     <= grant ? req1_b  : req0_b;
                op_q    <= grant ? req1_op : req0_op;
                owner_q <= grant;
            end
            if (state_q == StExec) begin
                result_q <= alu_y;
            end
            if (rsp_fire) begin
                last_grant_q <= owner_q;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table, scoreboard of accepted ops, and
// hand-written sequences for arbitration, backpressure, reset and idle hold.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [1:0] alu_op;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] delivered[$];
    int         grants[$];

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .busy       (busy)
    );

    // The shared ALU: op 11 is A + ~B, i.e. A - B - 1 modulo 256.
    always_comb begin
        case (alu_op)
            2'b00:   alu_y = alu_a & alu_b;
            2'b01:   alu_y = alu_a | alu_b;
            2'b10:   alu_y = alu_a + alu_b;
            default: alu_y = alu_a - alu_b - 8'd1;
        endcase
    end

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a + b;
            default: return a + ~b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic rv(input int id);
        return (id == 0) ? rsp0_valid : rsp1_valid;
    endfunction
    function automatic logic [7:0] rd(input int id);
        return (id == 0) ? rsp0_data : rsp1_data;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic wait_grants(input int target, input string name);
        int c = 0;
        while (grants.size() < target && c < 100) begin
            @(posedge clk); #1; c++;
        end
        if (grants.size() < target) chk(name, grants.size(), target);
    endtask

    task automatic wait_deliv(input int target, input string name);
        int c = 0;
        while (delivered.size() < target && c < 100) begin
            @(posedge clk); #1; c++;
        end
        if (delivered.size() < target) chk(name, delivered.size(), target);
    endtask

    // Scoreboard: handshakes are observed mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back({1'b0, ref_alu(req0_a, req0_b, req0_op)});
                grants.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back({1'b1, ref_alu(req1_a, req1_b, req1_op)});
                grants.push_back(1);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q.size() == 0) chk("sb_rsp0_unexpected", exp_q.size(), 1);
                else chk("sb_rsp0", {1'b0, rsp0_data}, exp_q.pop_front());
                delivered.push_back({1'b0, rsp0_data});
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q.size() == 0) chk("sb_rsp1_unexpected", exp_q.size(), 1);
                else chk("sb_rsp1", {1'b1, rsp1_data}, exp_q.pop_front());
                delivered.push_back({1'b1, rsp1_data});
            end
        end
    end

    // Handshake cycle, one EXEC cycle, then RESP with same-cycle rsp_ready.
    task automatic run_vec(input vec_t v, input string name);
        logic ok = 1'b0;
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rdy(v.id)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_accept"}, ok, 1'b1);
        chk({name, "_busy_idle"}, busy, 1'b0);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 8'h00, 8'h00, 2'b00);
        @(negedge clk);
        chk({name, "_exec"}, {busy, rv(v.id)}, 2'b10);
        @(negedge clk);
        chk({name, "_resp"}, {busy, rv(v.id), rv(1 - v.id)}, 3'b110);
        chk({name, "_data"}, rd(v.id), v.exp);
        @(negedge clk);
        chk({name, "_back_idle"}, {busy, rv(0), rv(1)}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, d0;
        vecs[0] = '{0, 8'hF0, 8'h3C, 2'b00, 8'h30};
        vecs[1] = '{1, 8'h0F, 8'hA0, 2'b01, 8'hAF};
        vecs[2] = '{0, 8'h7F, 8'h01, 2'b10, 8'h80};
        vecs[3] = '{1, 8'hFF, 8'h01, 2'b10, 8'h00};
        vecs[4] = '{0, 8'h05, 8'h02, 2'b11, 8'h02};
        vecs[5] = '{1, 8'h10, 8'h20, 2'b11, 8'hEF};
        vecs[6] = '{0, 8'hAA, 8'h55, 2'b01, 8'hFF};
        vecs[7] = '{1, 8'hC3, 8'h3C, 2'b00, 8'h00};

        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h12, 8'h34, 2'b10);
        set_req(1, 1'b1, 8'h56, 8'h78, 2'b01);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #12;
        chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
        chk("reset_outputs", {busy, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                              alu_a, alu_b, alu_op}, 39'd0);
        set_req(0, 1'b0, 8'h00, 8'h00, 2'b00);
        set_req(1, 1'b0, 8'h00, 8'h00, 2'b00);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Simultaneous requests straight after reset: requester 0 first.
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        g0 = grants.size();
        d0 = delivered.size();
        set_req(0, 1'b1, 8'h7F, 8'h01, 2'b10);
        set_req(1, 1'b1, 8'h0F, 8'hA0, 2'b01);
        wait_grants(g0 + 1, "simul_grant0_timeout");
        req0_valid = 1'b0;
        wait_grants(g0 + 2, "simul_grant1_timeout");
        req1_valid = 1'b0;
        wait_deliv(d0 + 2, "simul_deliv_timeout");
        chk("simul_order", {grants[g0][0], grants[g0+1][0]}, 2'b01);
        chk("simul_first", delivered[d0], {1'b0, 8'h80});
        chk("simul_second", delivered[d0+1], {1'b1, 8'hAF});

        // Fairness: both valid for eight operations.
        @(posedge clk); #1;
        g0 = grants.size();
        d0 = delivered.size();
        set_req(0, 1'b1, 8'h11, 8'h22, 2'b10);
        set_req(1, 1'b1, 8'h44, 8'h0F, 2'b00);
        wait_grants(g0 + 8, "fair_timeout");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_deliv(d0 + 8, "fair_deliv_timeout");
        chk("fair_first", grants[g0], 0);
        for (int k = 1; k < 8; k++) chk("fair_alt", grants[g0+k], 1 - grants[g0+k-1]);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure on requester 1, with both requesters re-requesting meanwhile.
        @(posedge clk); #1;
        g0 = grants.size();
        d0 = delivered.size();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        set_req(1, 1'b1, 8'h5A, 8'h0F, 2'b00);
        wait_grants(g0 + 1, "bp_accept_timeout");
        set_req(0, 1'b1, 8'h01, 8'h02, 2'b10);
        for (int c = 0; c < 10 && !rsp1_valid; c++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold", {rsp1_valid, rsp1_data, rsp0_valid, req0_ready, req1_ready, busy},
                {1'b1, 8'h0A, 4'b0001});
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", {busy, req0_ready, req1_ready}, 3'b010);
        wait_grants(g0 + 2, "bp_g2_timeout");
        req0_valid = 1'b0;
        wait_grants(g0 + 3, "bp_g3_timeout");
        req1_valid = 1'b0;
        wait_deliv(d0 + 3, "bp_deliv_timeout");
        chk("bp_order", {grants[g0][0], grants[g0+1][0], grants[g0+2][0]}, 3'b101);

        // Asynchronous reset while in EXEC discards the operation.
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        set_req(0, 1'b1, 8'h33, 8'h44, 2'b10);
        for (int c = 0; c < 20 && !req0_ready; c++) @(negedge clk);
        @(posedge clk); #3;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_outputs", {busy, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, alu_a,
                                 alu_b, alu_op, req0_ready, req1_ready}, 41'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", {rsp0_valid, rsp1_valid, busy}, 3'b000);
        end
        run_vec('{0, 8'h05, 8'h02, 2'b11, 8'h02}, "post_rst");

        // Idle: operand registers keep the last operation.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_hold", {alu_a, alu_b, alu_op, busy, rsp0_valid, rsp1_valid, req0_ready,
                              req1_ready}, {8'h05, 8'h02, 2'b11, 5'b00000});
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
